// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared defaults, FSM states and bit-reverse helper for the FFT reorder buffer
package fft_pkg;

    localparam int FFT_WIDTH   = 8;
    localparam int FFT_DECIMAL = 4;
    localparam int FFT_LOG2N   = 3;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Mirrors the low log2n bits of k; bits above log2n come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] k, input int log2n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < log2n; i++) begin
            r[log2n-1-i] = k[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_bank.sv
// rtl/fft_bitrev_bank.sv - N-entry {re,im} register array, one write port, one asynchronous read port
module fft_bitrev_bank #(
    parameter int WIDTH = 8,
    parameter int LOG2N = 3
) (
    input  logic               clk,
    input  logic               we,
    input  logic [LOG2N-1:0]   waddr,
    input  logic [2*WIDTH-1:0] wdata,
    input  logic [LOG2N-1:0]   raddr,
    output logic [2*WIDTH-1:0] rdata
);

    localparam int N = 2**LOG2N;

    logic [2*WIDTH-1:0] mem_q [N];
    logic [2*WIDTH-1:0] mem_d [N];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Contents are never cleared; the owner only exposes them once a frame is complete.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_bitrev_buffer.sv
// rtl/fft_bitrev_buffer.sv - natural-order in, bit-reversed-order out frame buffer; FFT_BITREV_PINGPONG_EN selects two banks
module fft_bitrev_buffer
    import fft_pkg::*;
#(
    parameter int WIDTH   = FFT_WIDTH,
    parameter int DECIMAL = FFT_DECIMAL,
    parameter int LOG2N   = FFT_LOG2N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last
);

    localparam logic [LOG2N-1:0] CNT_LAST = '1;
    localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);

    if (DECIMAL < 0 || DECIMAL >= WIDTH) begin : g_bad_format
        $error("fft_bitrev_buffer: DECIMAL must lie in [0, WIDTH)");
    end

    logic [LOG2N-1:0]   wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0]   rd_cnt_q, rd_cnt_d;
    logic [LOG2N-1:0]   rd_addr;
    logic [2*WIDTH-1:0] wr_word, rd_word;
    logic               in_fire;

    assign wr_word = {in_re, in_im};
    assign in_fire = in_valid & in_ready;
    assign rd_addr = LOG2N'(bitrev(32'(rd_cnt_q), LOG2N));

`ifdef FFT_BITREV_PINGPONG_EN
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [1:0]          full_q, full_d;
    logic [2*WIDTH-1:0]  bank_rdata [2];

    // Both sides alternate banks strictly, so frames leave in the order they arrived.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        in_ready  = ~full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        if (in_valid && !full_q[wr_bank_q]) begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
            if (wr_cnt_q == CNT_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        if (full_q[rd_bank_q] && out_ready) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
            if (rd_cnt_q == CNT_LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_bitrev_bank #(
            .WIDTH (WIDTH),
            .LOG2N (LOG2N)
        ) u_bank (
            .clk   (clk),
            .we    (in_fire && (wr_bank_q == 1'(b))),
            .waddr (wr_cnt_q),
            .wdata (wr_word),
            .raddr (rd_addr),
            .rdata (bank_rdata[b])
        );
    end

    assign rd_word = bank_rdata[rd_bank_q];
`else
    state_t state_q, state_d;

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_cnt_d = wr_cnt_q + CNT_ONE;
                    if (wr_cnt_q == CNT_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    rd_cnt_d = rd_cnt_q + CNT_ONE;
                    if (rd_cnt_q == CNT_LAST) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    fft_bitrev_bank #(
        .WIDTH (WIDTH),
        .LOG2N (LOG2N)
    ) u_bank (
        .clk   (clk),
        .we    (in_fire),
        .waddr (wr_cnt_q),
        .wdata (wr_word),
        .raddr (rd_addr),
        .rdata (rd_word)
    );
`endif

    // Stale memory is masked so nothing leaks out while no frame is presented.
    assign out_re   = out_valid ? rd_word[2*WIDTH-1:WIDTH] : '0;
    assign out_im   = out_valid ? rd_word[WIDTH-1:0]       : '0;
    assign out_idx  = out_valid ? rd_addr                  : '0;
    assign out_last = out_valid && (rd_cnt_q == CNT_LAST);

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// tb/tb_fft_bitrev_buffer.sv - directed self-checking bench for fft_bitrev_buffer (N=8, WIDTH=8)
module tb_fft_bitrev_buffer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_re;
    logic [7:0] in_im;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_re;
    logic [7:0] out_im;
    logic [2:0] out_idx;
    logic       out_last;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [7:0] fr_re [16];
    logic [7:0] fr_im [16];
    int         br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_bitrev_buffer #(
        .WIDTH   (8),
        .DECIMAL (4),
        .LOG2N   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Streams nfr frames from fr_re/fr_im while tracking the expected handshake state from its own counts.
    task automatic run_frames(input int nfr, input bit toggle, input int exp_cycles);
        int  in_i = 0;
        int  out_k = 0;
        int  cyc = 0;
        int  total = nfr * 8;
        int  full_in;
        int  k;
        int  nat;
        bit  rdy_e;
        bit  val_e;
        while ((in_i < total || out_k < total) && cyc < 200) begin
            full_in = (in_i / 8) * 8;
            val_e   = (out_k < full_in);
`ifdef FFT_BITREV_PINGPONG_EN
            rdy_e   = ((in_i / 8) - (out_k / 8)) < 2;
`else
            rdy_e   = (out_k == full_in);
`endif
            chk("in_ready", 32'(in_ready), 32'(rdy_e));
            chk("out_valid", 32'(out_valid), 32'(val_e));
            if (val_e) begin
                k   = out_k % 8;
                nat = br_tab[k];
                chk("out_re", 32'(out_re), 32'(fr_re[(out_k / 8) * 8 + nat]));
                chk("out_im", 32'(out_im), 32'(fr_im[(out_k / 8) * 8 + nat]));
                chk("out_idx", 32'(out_idx), 32'(nat));
                chk("out_last", 32'(out_last), 32'(k == 7));
            end
            in_valid  = (in_i < total);
            in_re     = (in_i < total) ? fr_re[in_i] : 8'h00;
            in_im     = (in_i < total) ? fr_im[in_i] : 8'h00;
            out_ready = toggle ? cyc[0] : 1'b1;
            step();
            if (in_valid && rdy_e) in_i++;
            if (out_ready && val_e) out_k++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("frames_done", 32'(out_k), 32'(total));
        if (exp_cycles >= 0) begin
            chk("cycles", 32'(cyc), 32'(exp_cycles));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_re     = 8'h00;
        in_im     = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_out_re", 32'(out_re), 32'd0);
        chk("rst_out_im", 32'(out_im), 32'd0);
        rst = 1'b0;

        // 1: ramp, free-flowing output; 8 fill + 8 drain cycles
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = 8'(i);
            fr_im[i] = 8'h00;
        end
        run_frames(1, 1'b0, 16);

        // 2: same frame with downstream stalling every other cycle
        run_frames(1, 1'b1, -1);

        // 3: two back-to-back frames
        for (int i = 0; i < 8; i++) begin
            fr_re[i]     = 8'h10 + 8'(i);
            fr_im[i]     = 8'h00;
            fr_re[8 + i] = 8'h00;
            fr_im[8 + i] = 8'hF0 + 8'(i);
        end
`ifdef FFT_BITREV_PINGPONG_EN
        run_frames(2, 1'b0, 24);
`else
        run_frames(2, 1'b0, 32);
`endif

        // 4: reset after a partial load discards it
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_re    = 8'hAA;
            in_im    = 8'h55;
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = 8'h30 + 8'(i);
            fr_im[i] = 8'h40 + 8'(i);
        end
        run_frames(1, 1'b0, 16);

        // 5: reset during drain after three outputs
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_re    = 8'hC0 + 8'(i);
            in_im    = 8'hD0 + 8'(i);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();
        chk("t5_pre_rst_valid", 32'(out_valid), 32'd1);
        chk("t5_pre_rst_idx", 32'(out_idx), 32'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_idle_valid", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = 8'h60 + 8'(i);
            fr_im[i] = 8'h70 + 8'(i);
        end
        run_frames(1, 1'b0, 16);

        // 6: signed extremes at natural index 1 come out fifth
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = 8'h20 + 8'(i);
            fr_im[i] = 8'h08 + 8'(i);
        end
        fr_re[1] = 8'h80;
        fr_im[1] = 8'h7F;
        run_frames(1, 1'b0, 16);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
